// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the MMIO UART transmitter slice.
package mmio_uart_tx_pkg;

  // Bits per UART character (8N1 framing carries one byte per frame).
  localparam int BITS_PER_BYTE = 8;

  // Default MMIO word width of the core.
  localparam int MMIO_BUS_WIDTH = 32;

  // Transmit FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Bundle between the processor's MMIO word and the UART transmitter:
// the word going in plus the serial line and status coming back.
interface mmio_uart_tx_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
);
  logic [BUS_WIDTH-1:0]          mmio_data;
  logic                          uart_tx;
  logic                          tx_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  // Processor / system side: drives the word, observes line and status.
  modport master (
    output mmio_data,
    input  uart_tx,
    input  tx_busy,
    input  fifo_count,
    input  overflow
  );

  // Transmitter side.
  modport slave (
    input  mmio_data,
    output uart_tx,
    output tx_busy,
    output fifo_count,
    output overflow
  );
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// mmio_fifo: small synchronous circular FIFO shared by MMIO peripherals.
// The head entry is visible combinationally so a consumer can load it on
// the same edge it pops. A push into a full FIFO is taken only when a pop
// frees the slot in the same cycle.
module mmio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: watches the processor's MMIO word, queues every change and
// sends each queued word as BUS_WIDTH/8 back-to-back 8N1 frames, LSB byte first.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int BUS_WIDTH    = MMIO_BUS_WIDTH,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int NBYTES = BUS_WIDTH / BITS_PER_BYTE;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [BUS_WIDTH-1:0]          last_val_reg;
  logic                          overflow_reg;
  tx_state_t                     state_reg;
  logic [CNT_W-1:0]              baud_cnt_reg;
  logic [2:0]                    bit_idx_reg;
  logic [BYTE_W-1:0]             byte_idx_reg;
  logic [BUS_WIDTH-1:0]          sh_reg;
  logic                          uart_tx_reg;
  logic                          line_next;

  logic                          push_req;
  logic                          pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [BUS_WIDTH-1:0]          head;
  logic                          baud_wrap;

  assign push_req  = (bus.mmio_data != last_val_reg);
  assign pop       = (state_reg == ST_IDLE) & ~fifo_empty;
  assign baud_wrap = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  mmio_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .pop     (pop),
    .wr_data (bus.mmio_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Change detector history and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_val_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      last_val_reg <= bus.mmio_data;
      if (push_req && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Line level implied by the current state; sh_reg[0] is always the next data bit.
  always_comb begin
    line_next = 1'b1;
    case (state_reg)
      ST_START: line_next = 1'b0;
      ST_DATA:  line_next = sh_reg[0];
      default:  line_next = 1'b1;
    endcase
  end

  // Transmit FSM with baud counter; the line flop follows the state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      sh_reg       <= '0;
      uart_tx_reg  <= 1'b1;
    end else begin
      uart_tx_reg <= line_next;
      case (state_reg)
        ST_IDLE: begin
          baud_cnt_reg <= '0;
          if (!fifo_empty) begin
            sh_reg       <= head;
            byte_idx_reg <= '0;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            baud_cnt_reg <= '0;
            sh_reg       <= sh_reg >> 1;
            if (bit_idx_reg == 3'(BITS_PER_BYTE - 1)) begin
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_wrap) begin
            baud_cnt_reg <= '0;
            if (byte_idx_reg != BYTE_W'(NBYTES - 1)) begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
              state_reg    <= ST_START;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.uart_tx    = uart_tx_reg;
  assign bus.tx_busy    = (state_reg != ST_IDLE) | (fifo_count != '0);
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: timing-level reference model feeding a frame
// scoreboard, a UART line decoder as monitor, and per-cycle status checks.
module tb_mmio_uart_tx;
  localparam int W     = 32;
  localparam int CPB   = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * CPB;
  localparam int WORD  = (W / 8) * FRAME;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic clk = 1'b0;
  logic rst;

  mmio_uart_tx_if #(.BUS_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  mmio_uart_tx #(
    .BUS_WIDTH    (W),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0;

  // reference model state
  int          cyc = 0;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_last;
  bit          m_ovf = 1'b0;
  int          m_next_pop = 0;
  int          m_last_pop = 0;
  bit          m_rst_edge = 1'b0;
  bit          chk_en = 1'b0;
  frame_t      exp_q[$];
  bit          mon_busy = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: the transmitter takes a word from the queue whenever it is
  // free, then spends one full word time (4 frames) before it can take another.
  initial begin : model
    logic [W-1:0] w;
    bit           pop_now;
    frame_t       f;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_q.delete();
        exp_q.delete();
        m_last     = '0;
        m_ovf      = 1'b0;
        m_next_pop = 0;
        m_rst_edge = 1'b1;
        chk_en     = 1'b1;
      end else begin
        m_rst_edge = 1'b0;
        pop_now = (cyc >= m_next_pop) && (m_q.size() != 0);
        if (pop_now) begin
          w = m_q.pop_front();
          for (int i = 0; i < W / 8; i++) begin
            f.data  = w[8*i +: 8];
            f.start = cyc + 1 + FRAME * i;
            exp_q.push_back(f);
          end
          m_last_pop = cyc;
          m_next_pop = cyc + WORD + 1;
        end
        if (bus.mmio_data != m_last) begin
          if (m_q.size() < D) m_q.push_back(bus.mmio_data);
          else m_ovf = 1'b1;
        end
        m_last = bus.mmio_data;
      end
    end
  end

  // Status outputs compared against the model every cycle.
  initial begin : status_chk
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
        check("overflow", 64'(bus.overflow), 64'(m_ovf));
        check("tx_busy", 64'(bus.tx_busy), 64'((cyc + 1 < m_next_pop) || (m_q.size() != 0)));
        if (m_rst_edge) check("reset_line", 64'(bus.uart_tx), 64'd1);
      end
    end
  end

  // Monitor: decode frames off the line and pop the scoreboard at each start bit.
  initial begin : line_mon
    frame_t     e;
    bit         have_exp;
    bit         aborted;
    logic [7:0] got;
    logic       start_lvl;
    logic       stop_lvl;
    int         start_cyc;
    forever begin
      @(negedge clk);
      if (!chk_en || rst || bus.uart_tx !== 1'b0) continue;
      mon_busy  = 1'b1;
      start_cyc = cyc;
      have_exp  = (exp_q.size() != 0);
      if (have_exp) begin
        e = exp_q.pop_front();
        check("frame_start_cycle", 64'(start_cyc), 64'(e.start));
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", start_cyc);
      end
      aborted = 1'b0;
      repeat (2) begin @(negedge clk); if (rst) aborted = 1'b1; end
      start_lvl = bus.uart_tx;
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
        got[b] = bus.uart_tx;
      end
      repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
      stop_lvl = bus.uart_tx;
      if (!aborted && have_exp) begin
        check("start_bit", 64'(start_lvl), 64'd0);
        check("frame_data", 64'(got), 64'(e.data));
        check("stop_bit", 64'(stop_lvl), 64'd1);
        n_frames++;
        $display("frame %0d: byte %02h at cycle %0d", n_frames, got, start_cyc);
      end
      mon_busy = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_data(input logic [W-1:0] v);
    bus.mmio_data = v;
    tick(1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.mmio_data = '0;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((m_q.size() != 0 || cyc + 1 < m_next_pop || exp_q.size() != 0 || mon_busy) && n < max) begin
      tick(1);
      n++;
    end
    tick(3);
    check("idle_within_budget", 64'(n < max), 64'd1);
  endtask

  initial begin : stim
    int f0;
    int guard;
    logic [W-1:0] v;
    logic [W-1:0] prev;

    // Reset with a non-zero word present.
    rst = 1'b1;
    bus.mmio_data = 32'h12345678;
    tick(3);
    check("rst_uart_tx", 64'(bus.uart_tx), 64'd1);
    check("rst_tx_busy", 64'(bus.tx_busy), 64'd0);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    tick(1);
    check("queued_after_release", 64'(bus.fifo_count), 64'd1);
    wait_idle(400);

    // Single word from a cleared history.
    do_reset(2);
    tick(2);
    f0 = n_frames;
    set_data(32'h44434241);
    wait_idle(400);
    check("single_word_frames", 64'(n_frames - f0), 64'd4);
    check("single_word_idle", 64'(bus.tx_busy), 64'd0);

    // Steady input is sent exactly once.
    f0 = n_frames;
    bus.mmio_data = 32'h000000AA;
    tick(1000);
    wait_idle(400);
    check("steady_frames", 64'(n_frames - f0), 64'd4);

    // Six changes on consecutive cycles: one popped, four buffered, one dropped.
    f0 = n_frames;
    for (int i = 0; i < 6; i++) set_data(32'hC0DE0000 + 32'(i));
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    check("ovf_full", 64'(bus.fifo_count), 64'(D));
    wait_idle(1200);
    check("ovf_frames", 64'(n_frames - f0), 64'd20);
    check("ovf_sticky", 64'(bus.overflow), 64'd1);

    // Full FIFO, change coinciding with the IDLE pop.
    do_reset(2);
    f0 = n_frames;
    for (int i = 0; i < 5; i++) set_data(32'h5A000000 + 32'(i * 3 + 1));
    guard = 0;
    while (cyc + 1 < m_next_pop && guard < 400) begin
      tick(1);
      guard++;
    end
    set_data(32'hFEEDBEEF);
    check("pop_push_no_ovf", 64'(bus.overflow), 64'd0);
    check("pop_push_count", 64'(bus.fifo_count), 64'(D));
    wait_idle(1500);
    check("pop_push_frames", 64'(n_frames - f0), 64'd24);

    // Randomised changes, repeats and gaps.
    prev = bus.mmio_data;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) == 0) ? prev : 32'($urandom);
      prev = v;
      set_data(v);
      tick($urandom_range(0, 60));
    end
    wait_idle(5000);

    // Reset during data bit 3 of byte 2, with a second word waiting.
    do_reset(1);
    set_data(32'hA1B2C3D4);
    set_data(32'h55667788);
    guard = 0;
    while (cyc < m_last_pop + 98 && guard < 400) begin
      tick(1);
      guard++;
    end
    rst = 1'b1;
    bus.mmio_data = '0;
    tick(1);
    check("abort_line_high", 64'(bus.uart_tx), 64'd1);
    check("abort_fifo_empty", 64'(bus.fifo_count), 64'd0);
    rst = 1'b0;
    f0 = n_frames;
    tick(300);
    check("abort_no_frames", 64'(n_frames - f0), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
